alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer_if.sv | 41 ++++
 rtl/alu_cmd_issuer.sv | 91 +++++++++
 tb/tb_alu_cmd_issuer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response bundle for alu_cmd_issuer.
// master = command source / ALU / response sink, slave = issuer.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [3:0] acc;
    logic [7:0] op_count;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_operand,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero,
        output rsp_ready,
        input  acc, op_count
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_operand,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero,
        input  rsp_ready,
        output acc, op_count
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Accumulator-based command issuer driving an external 4-bit ALU.
// One command in flight: IDLE -> (ISSUE) -> RESP -> IDLE.
module alu_cmd_issuer (
    input logic              clk,
    input logic              rst,
    alu_cmd_issuer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] acc_q;
    logic       carry_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [2:0] alu_sel_q;
    logic [7:0] op_count_q;
    logic       rsp_valid_q;
    logic       cmd_ready_q;

    // Sequencer: accept, issue to the ALU, hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc_q       <= 4'h0;
            carry_q     <= 1'b0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_sel_q   <= 3'b000;
            op_count_q  <= 8'h00;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_load) begin
                            acc_q       <= bus.cmd_operand;
                            carry_q     <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            alu_a_q   <= acc_q;
                            alu_b_q   <= bus.cmd_operand;
                            alu_sel_q <= bus.cmd_op;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    acc_q <= bus.alu_result;
                    // Only add/sub produce a meaningful carry.
                    if (alu_sel_q == 3'b000 || alu_sel_q == 3'b001)
                        carry_q <= bus.alu_carry;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        op_count_q  <= op_count_q + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = acc_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_zero   = (acc_q == 4'h0);
    assign bus.acc        = acc_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural 4-bit ALU.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_alu_cmd_issuer;

    logic clk;
    logic rst;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU the issuer drives.
    always_comb begin
        logic [4:0] t;
        t = 5'd0;
        bus.alu_carry = 1'b0;
        unique case (bus.alu_sel)
            3'b000: begin
                t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_carry = t[4];
            end
            3'b001: begin
                t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                bus.alu_carry = t[4];
            end
            3'b010: t = {1'b0, bus.alu_a & bus.alu_b};
            3'b011: t = {1'b0, bus.alu_a | bus.alu_b};
            3'b100: t = {1'b0, bus.alu_a ^ bus.alu_b};
            3'b101: t = {1'b0, ~bus.alu_a};
            3'b110: t = {1'b0, bus.alu_a[2:0], 1'b0};
            default: t = {2'b00, bus.alu_a[3:1]};
        endcase
        bus.alu_result = t[3:0];
    end

    int n_checks = 0;
    int n_pass   = 0;

    // {result[3:0], carry, zero}
    logic [5:0] sb[$];
    logic [5:0] e_mon;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tmo(input string name);
        n_checks++;
        $display("FAIL %s: timeout got none expected event", name);
    endtask

    // Monitor: every response handshake is compared against the queue.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_result), 32'hDEAD);
            end else begin
                e_mon = sb.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(e_mon[5:2]));
                chk("rsp_carry", 32'(bus.rsp_carry), 32'(e_mon[1]));
                chk("rsp_zero", 32'(bus.rsp_zero), 32'(e_mon[0]));
            end
        end
    end

    // Present a command and return #1 after the accepting edge.
    task automatic issue(input logic ld, input logic [2:0] op,
                         input logic [3:0] opd);
        int k;
        bus.cmd_load    = ld;
        bus.cmd_op      = op;
        bus.cmd_operand = opd;
        bus.cmd_valid   = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.cmd_ready) tmo("cmd_accept");
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // Full transaction with latency checks and response drain.
    task automatic run(input logic ld, input logic [2:0] op,
                       input logic [3:0] opd, input logic [3:0] res,
                       input logic c);
        int k;
        sb.push_back({res, c, (res == 4'h0)});
        issue(ld, op, opd);
        if (ld) begin
            @(negedge clk);
            chk("lat_load", 32'(bus.rsp_valid), 32'd1);
        end else begin
            @(negedge clk);
            chk("lat_issue", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            chk("lat_alu", 32'(bus.rsp_valid), 32'd1);
        end
        k = 0;
        while (!(bus.rsp_valid && bus.rsp_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!(bus.rsp_valid && bus.rsp_ready)) tmo("rsp_handshake");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got none expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_load    = 1'b0;
        bus.cmd_op      = 3'b000;
        bus.cmd_operand = 4'h0;
        bus.rsp_ready   = 1'b1;
        #2;
        chk("rst_acc", 32'(bus.acc), 32'h0);
        chk("rst_cnt", 32'(bus.op_count), 32'h0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD with carry out, then AND holds carry.
        run(1, 3'b000, 4'h9, 4'h9, 1'b0);
        run(0, 3'b000, 4'h8, 4'h1, 1'b1);
        run(0, 3'b010, 4'hF, 4'h1, 1'b1);
        // SUB borrow, then no borrow.
        run(1, 3'b000, 4'h3, 4'h3, 1'b0);
        run(0, 3'b001, 4'h5, 4'hE, 1'b1);
        run(0, 3'b001, 4'h1, 4'hD, 1'b0);
        // XOR to zero.
        run(1, 3'b000, 4'hF, 4'hF, 1'b0);
        run(0, 3'b100, 4'hF, 4'h0, 1'b0);
        // Load leaves the ALU drive untouched.
        run(1, 3'b000, 4'hC, 4'hC, 1'b0);
        chk("load_keeps_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}),
            32'({4'hF, 4'hF, 3'b100}));
        // NOT still captures operand B; shifts, OR.
        run(0, 3'b101, 4'h7, 4'h3, 1'b0);
        chk("not_alu_b", 32'(bus.alu_b), 32'h7);
        chk("not_alu_sel", 32'(bus.alu_sel), 32'h5);
        run(0, 3'b110, 4'h2, 4'h6, 1'b0);
        run(0, 3'b111, 4'h0, 4'h3, 1'b0);
        run(0, 3'b011, 4'h8, 4'hB, 1'b0);

        // Back-pressure with a pending second command.
        bus.rsp_ready = 1'b0;
        sb.push_back({4'h6, 1'b0, 1'b0});
        issue(1, 3'b000, 4'h6);
        sb.push_back({4'hA, 1'b0, 1'b0});
        bus.cmd_load    = 1'b1;
        bus.cmd_operand = 4'hA;
        bus.cmd_valid   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
            chk("stall_result", 32'(bus.rsp_result), 32'h6);
            chk("stall_ready", 32'(bus.cmd_ready), 32'h0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_hs_ready", 32'(bus.cmd_ready), 32'h1);
        chk("post_hs_valid", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("second_valid", 32'(bus.rsp_valid), 32'h1);
        chk("second_acc", 32'(bus.acc), 32'hA);
        @(posedge clk);
        #1;

        // Reset during ISSUE discards the command.
        run(1, 3'b000, 4'h5, 4'h5, 1'b0);
        bus.cmd_load    = 1'b0;
        bus.cmd_op      = 3'b010;
        bus.cmd_operand = 4'h3;
        bus.cmd_valid   = 1'b1;
        @(negedge clk);
        chk("pre_issue_ready", 32'(bus.cmd_ready), 32'h1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        #1 chk("issue_sel", 32'(bus.alu_sel), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("arst_acc", 32'(bus.acc), 32'h0);
        chk("arst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("arst_sel", 32'(bus.alu_sel), 32'h0);
        chk("arst_b", 32'(bus.alu_b), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(bus.cmd_ready), 32'h1);
        chk("rel_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rel_cnt", 32'(bus.op_count), 32'h0);
        @(posedge clk);
        #1;

        // op_count wrap over 256 loads.
        for (int i = 0; i < 255; i++) begin
            run(1, 3'b000, 4'(i), 4'(i), 1'b0);
        end
        chk("cnt_255", 32'(bus.op_count), 32'hFF);
        run(1, 3'b000, 4'h1, 4'h1, 1'b0);
        chk("cnt_wrap", 32'(bus.op_count), 32'h00);

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
